cp0_reg: RTL and testbench



---
 rtl/cp0_reg.sv | 146 ++++++++++++++
 tb/tb_cp0_reg.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_reg.sv
// Coprocessor-0 register bank: Count/Compare/Status/Cause/EPC/PrId/Config,
// timer interrupt generation and precise-exception bookkeeping.
module cp0_reg #(
   parameter logic [31:0] PRID_VALUE   = 32'h0048_0102,
   parameter logic [31:0] CONFIG_VALUE = 32'h0000_8000,
   parameter logic [31:0] STATUS_RST   = 32'h1000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        we_i,
   input  logic [4:0]  waddr_i,
   input  logic [31:0] data_i,
   input  logic [4:0]  raddr_i,
   input  logic [5:0]  int_i,
   input  logic [31:0] excepttype_i,
   input  logic [31:0] current_inst_addr_i,
   input  logic        is_in_delayslot_i,
   output logic [31:0] data_o,
   output logic [31:0] count_o,
   output logic [31:0] compare_o,
   output logic [31:0] status_o,
   output logic [31:0] cause_o,
   output logic [31:0] epc_o,
   output logic [31:0] config_o,
   output logic [31:0] prid_o,
   output logic        timer_int_o
);

   localparam logic [4:0] REG_COUNT   = 5'd9;
   localparam logic [4:0] REG_COMPARE = 5'd11;
   localparam logic [4:0] REG_STATUS  = 5'd12;
   localparam logic [4:0] REG_CAUSE   = 5'd13;
   localparam logic [4:0] REG_EPC     = 5'd14;
   localparam logic [4:0] REG_PRID    = 5'd15;
   localparam logic [4:0] REG_CONFIG  = 5'd16;

   // Cause bits software may write: IV, WP, IP[1:0].
   localparam logic [31:0] CAUSE_WMASK = 32'h00C0_0300;

   logic [31:0] count_q, count_d;
   logic [31:0] compare_q, compare_d;
   logic [31:0] status_q, status_d;
   logic [31:0] cause_q, cause_d;
   logic [31:0] epc_q, epc_d;
   logic        timer_int_q, timer_int_d;

   logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;
   logic        exc_take;
   logic        exc_eret;
   logic [4:0]  exc_code;

   always_comb begin
      wr_count   = we_i && (waddr_i == REG_COUNT);
      wr_compare = we_i && (waddr_i == REG_COMPARE);
      wr_status  = we_i && (waddr_i == REG_STATUS);
      wr_cause   = we_i && (waddr_i == REG_CAUSE);
      wr_epc     = we_i && (waddr_i == REG_EPC);

      exc_take = 1'b0;
      exc_eret = 1'b0;
      exc_code = 5'd0;
      case (excepttype_i)
         32'h0000_0001: begin exc_take = 1'b1; exc_code = 5'h00; end
         32'h0000_0008: begin exc_take = 1'b1; exc_code = 5'h08; end
         32'h0000_000a: begin exc_take = 1'b1; exc_code = 5'h0a; end
         32'h0000_000c: begin exc_take = 1'b1; exc_code = 5'h0c; end
         32'h0000_000d: begin exc_take = 1'b1; exc_code = 5'h0d; end
         32'h0000_000e: exc_eret = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      count_d     = wr_count ? data_i : count_q + 32'd1;
      compare_d   = wr_compare ? data_i : compare_q;
      status_d    = wr_status ? data_i : status_q;
      epc_d       = wr_epc ? data_i : epc_q;
      cause_d     = wr_cause ? ((cause_q & ~CAUSE_WMASK) | (data_i & CAUSE_WMASK)) : cause_q;
      cause_d[15:10] = int_i;

      // A Compare write acknowledges the timer even if a match happens this cycle.
      if (wr_compare)
         timer_int_d = 1'b0;
      else if ((compare_q != 32'd0) && (count_q == compare_q))
         timer_int_d = 1'b1;
      else
         timer_int_d = timer_int_q;

      // Exception bookkeeping is applied after software writes so it wins on shared bits.
      if (exc_take) begin
         if (!status_q[1]) begin
            epc_d      = is_in_delayslot_i ? current_inst_addr_i - 32'd4 : current_inst_addr_i;
            cause_d[31] = is_in_delayslot_i;
         end
         status_d[1]  = 1'b1;
         cause_d[6:2] = exc_code;
      end else if (exc_eret) begin
         status_d[1] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q     <= 32'd0;
         compare_q   <= 32'd0;
         status_q    <= STATUS_RST;
         cause_q     <= 32'd0;
         epc_q       <= 32'd0;
         timer_int_q <= 1'b0;
      end else begin
         count_q     <= count_d;
         compare_q   <= compare_d;
         status_q    <= status_d;
         cause_q     <= cause_d;
         epc_q       <= epc_d;
         timer_int_q <= timer_int_d;
      end
   end

   // Read port shows committed state only; same-cycle writes are not bypassed.
   always_comb begin
      data_o = 32'd0;
      if (!rst) begin
         case (raddr_i)
            REG_COUNT:   data_o = count_q;
            REG_COMPARE: data_o = compare_q;
            REG_STATUS:  data_o = status_q;
            REG_CAUSE:   data_o = cause_q;
            REG_EPC:     data_o = epc_q;
            REG_PRID:    data_o = PRID_VALUE;
            REG_CONFIG:  data_o = CONFIG_VALUE;
            default:     data_o = 32'd0;
         endcase
      end
   end

   assign count_o     = count_q;
   assign compare_o   = compare_q;
   assign status_o    = status_q;
   assign cause_o     = cause_q;
   assign epc_o       = epc_q;
   assign config_o    = CONFIG_VALUE;
   assign prid_o      = PRID_VALUE;
   assign timer_int_o = timer_int_q;

endmodule

// File: tb/tb_cp0_reg.sv
// Testbench for cp0_reg: directed test-plan sequences plus random traffic,
// checked against a rule-level CP0 model through an expected-state queue.
module tb_cp0_reg;

  localparam logic [31:0] PRID   = 32'h0048_0102;
  localparam logic [31:0] CONFIG = 32'h0000_8000;
  localparam logic [31:0] ST_RST = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] data_i;
  logic [4:0]  raddr_i;
  logic [5:0]  int_i;
  logic [31:0] excepttype_i;
  logic [31:0] current_inst_addr_i;
  logic        is_in_delayslot_i;
  logic [31:0] data_o, count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o;
  logic        timer_int_o;

  cp0_reg dut (
    .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .data_i(data_i),
    .raddr_i(raddr_i), .int_i(int_i), .excepttype_i(excepttype_i),
    .current_inst_addr_i(current_inst_addr_i), .is_in_delayslot_i(is_in_delayslot_i),
    .data_o(data_o), .count_o(count_o), .compare_o(compare_o), .status_o(status_o),
    .cause_o(cause_o), .epc_o(epc_o), .config_o(config_o), .prid_o(prid_o),
    .timer_int_o(timer_int_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] count;
    logic [31:0] compare;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic [31:0] data;
    logic        timer;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // reference model state
  logic [31:0] m_count, m_compare, m_status, m_cause, m_epc;
  logic        m_timer;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      5'd16:   return CONFIG;
      default: return 32'd0;
    endcase
  endfunction

  // Advance the model by one edge using the inputs currently driven, queue the
  // expected post-edge outputs, then move to the next falling edge.
  task automatic tick();
    logic [31:0] n_count, n_compare, n_status, n_cause, n_epc;
    logic        n_timer, take;
    logic [4:0]  code;
    exp_t        e;
    if (rst) begin
      n_count = 0; n_compare = 0; n_status = ST_RST; n_cause = 0; n_epc = 0; n_timer = 0;
    end else begin
      n_count   = (we_i && waddr_i == 9) ? data_i : m_count + 32'd1;
      n_compare = (we_i && waddr_i == 11) ? data_i : m_compare;
      n_status  = (we_i && waddr_i == 12) ? data_i : m_status;
      n_epc     = (we_i && waddr_i == 14) ? data_i : m_epc;
      n_cause   = m_cause;
      if (we_i && waddr_i == 13) begin
        n_cause[9:8]   = data_i[9:8];
        n_cause[23:22] = data_i[23:22];
      end
      n_cause[15:10] = int_i;
      if (we_i && waddr_i == 11) n_timer = 1'b0;
      else if (m_compare != 0 && m_count == m_compare) n_timer = 1'b1;
      else n_timer = m_timer;
      take = 1'b0;
      code = 5'd0;
      if (excepttype_i == 32'h1) take = 1'b1;
      else if (excepttype_i == 32'h8 || excepttype_i == 32'ha || excepttype_i == 32'hc ||
               excepttype_i == 32'hd) begin
        take = 1'b1;
        code = excepttype_i[4:0];
      end
      if (take) begin
        if (m_status[1] == 1'b0) begin
          n_epc = is_in_delayslot_i ? current_inst_addr_i - 32'd4 : current_inst_addr_i;
          n_cause[31] = is_in_delayslot_i;
        end
        n_status[1]  = 1'b1;
        n_cause[6:2] = code;
      end else if (excepttype_i == 32'he) begin
        n_status[1] = 1'b0;
      end
    end
    m_count = n_count; m_compare = n_compare; m_status = n_status;
    m_cause = n_cause; m_epc = n_epc; m_timer = n_timer;
    e.count = m_count; e.compare = m_compare; e.status = m_status; e.cause = m_cause;
    e.epc = m_epc; e.timer = m_timer;
    e.data = rst ? 32'd0 : m_read(raddr_i);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // driver tasks
  task automatic idle();
    rst = 1'b0; we_i = 1'b0; waddr_i = 5'd0; data_i = 32'd0;
    excepttype_i = 32'd0; current_inst_addr_i = 32'd0; is_in_delayslot_i = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    idle();
    we_i = 1'b1; waddr_i = a; data_i = d;
    tick();
  endtask

  task automatic exc(input logic [31:0] t, input logic [31:0] pc, input logic ds);
    idle();
    excepttype_i = t; current_inst_addr_i = pc; is_in_delayslot_i = ds;
    tick();
  endtask

  task automatic do_reset(input int n);
    idle();
    rst = 1'b1;
    for (int i = 0; i < n; i++) tick();
    rst = 1'b0;
  endtask

  // monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("count_o", count_o, e.count);
        chk("compare_o", compare_o, e.compare);
        chk("status_o", status_o, e.status);
        chk("cause_o", cause_o, e.cause);
        chk("epc_o", epc_o, e.epc);
        chk("data_o", data_o, e.data);
        chk("timer_int_o", {31'd0, timer_int_o}, {31'd0, e.timer});
        chk("prid_o", prid_o, PRID);
        chk("config_o", config_o, CONFIG);
      end
    end
  end

  // stimulus
  initial begin
    int k;
    logic [31:0] kinds [10];
    logic [4:0]  addrs [8];
    kinds = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h1, 32'h8, 32'ha, 32'hc, 32'hd, 32'he};
    addrs = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd3};
    m_count = 0; m_compare = 0; m_status = 0; m_cause = 0; m_epc = 0; m_timer = 0;
    idle();
    raddr_i = 5'd15;
    int_i = 6'd0;
    @(negedge clk);

    // reset values and count start
    do_reset(2);
    rst = 1'b1;
    #1;
    chk("rst data_o", data_o, 32'd0);
    chk("rst status_o", status_o, ST_RST);
    chk("rst count_o", count_o, 32'd0);
    idle();
    raddr_i = 5'd9;
    for (int i = 0; i < 3; i++) tick();
    chk("count after release", count_o, 32'd3);

    // count wrap and write priority
    wr(5'd9, 32'hFFFF_FFFE);
    chk("count write", count_o, 32'hFFFF_FFFE);
    idle(); tick();
    chk("count ffffffff", count_o, 32'hFFFF_FFFF);
    tick();
    chk("count wrap", count_o, 32'd0);
    wr(5'd9, 32'd5);
    chk("count write wins", count_o, 32'd5);

    // timer
    raddr_i = 5'd11;
    wr(5'd11, 32'd20);
    wr(5'd9, 32'd15);
    idle();
    for (int i = 0; i < 5; i++) tick();
    chk("count at compare", count_o, 32'd20);
    chk("timer before", {31'd0, timer_int_o}, 32'd0);
    tick();
    chk("timer set", {31'd0, timer_int_o}, 32'd1);
    for (int i = 0; i < 12; i++) tick();
    chk("timer sticky", {31'd0, timer_int_o}, 32'd1);
    wr(5'd11, 32'd100);
    chk("timer cleared", {31'd0, timer_int_o}, 32'd0);

    // syscall in a delay slot, then overflow with EXL set
    raddr_i = 5'd14;
    exc(32'h8, 32'hBFC0_0104, 1'b1);
    chk("syscall epc", epc_o, 32'hBFC0_0100);
    chk("syscall bd", {31'd0, cause_o[31]}, 32'd1);
    chk("syscall code", {27'd0, cause_o[6:2]}, 32'h08);
    chk("syscall exl", {31'd0, status_o[1]}, 32'd1);
    exc(32'hc, 32'h0000_1234, 1'b0);
    chk("ov epc kept", epc_o, 32'hBFC0_0100);
    chk("ov code", {27'd0, cause_o[6:2]}, 32'h0c);
    exc(32'he, 32'd0, 1'b0);
    chk("eret exl", {31'd0, status_o[1]}, 32'd0);

    // cause write mask from a clean state
    do_reset(1);
    raddr_i = 5'd13;
    int_i = 6'd0;
    wr(5'd13, 32'hFFFF_FFFF);
    chk("cause mask", cause_o, 32'h00C0_0300);

    // write and exception collide on Status
    idle();
    we_i = 1'b1; waddr_i = 5'd12; data_i = 32'h0; excepttype_i = 32'h1;
    current_inst_addr_i = 32'h8000_0040;
    tick();
    chk("collide status", status_o, 32'h0000_0002);
    chk("collide code", {27'd0, cause_o[6:2]}, 32'h00);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      idle();
      rst = ($urandom_range(0, 63) == 0);
      we_i = ($urandom_range(0, 2) == 0);
      waddr_i = addrs[$urandom_range(0, 7)];
      k = $urandom_range(0, 3);
      data_i = (k == 0) ? m_count + $urandom_range(0, 8) : $urandom;
      if (waddr_i == 5'd9 && k == 1) data_i = m_compare - $urandom_range(0, 3);
      raddr_i = $urandom_range(0, 1) ? addrs[$urandom_range(0, 7)] : 5'($urandom_range(0, 31));
      int_i = 6'($urandom);
      excepttype_i = kinds[$urandom_range(0, 9)];
      current_inst_addr_i = $urandom;
      is_in_delayslot_i = 1'($urandom);
      tick();
    end
    idle();
    tick();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
